// File: rtl/acc_pkg.sv
// Shared opcode and control-state definitions for the bus accumulator.
package acc_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_NOP = 3'b000;
   localparam op_t OP_CLR = 3'b001;
   localparam op_t OP_INC = 3'b010;
   localparam op_t OP_DEC = 3'b011;
   localparam op_t OP_SHL = 3'b100;
   localparam op_t OP_SHR = 3'b101;
   localparam op_t OP_ROL = 3'b110;
   localparam op_t OP_ROR = 3'b111;

   // Low two opcode bits select the shift flavour once op[2] marks a shift.
   localparam logic [1:0] SH_SHL = 2'b00;
   localparam logic [1:0] SH_SHR = 2'b01;
   localparam logic [1:0] SH_ROL = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/acc_shift_step.sv
// One-bit shift/rotate of the accumulator, returning the new value and the bit moved out.
module acc_shift_step
   import acc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] next_a,
   output logic             bit_out
);

   always_comb begin
      next_a  = a;
      bit_out = 1'b0;
      case (mode)
         SH_SHL: begin
            next_a  = {a[WIDTH-2:0], 1'b0};
            bit_out = a[WIDTH-1];
         end
         SH_SHR: begin
            next_a  = {1'b0, a[WIDTH-1:1]};
            bit_out = a[0];
         end
         SH_ROL: begin
            next_a  = {a[WIDTH-2:0], a[WIDTH-1]};
            bit_out = a[WIDTH-1];
         end
         SH_ROR: begin
            next_a  = {a[0], a[WIDTH-1:1]};
            bit_out = a[0];
         end
         default: begin
            next_a  = a;
            bit_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/accumulator_shift_unit.sv
// Register A for the bus CPU: bus load/drive, clear/inc/dec and multi-cycle shifts with busy/done.
module accumulator_shift_unit
   import acc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   inout  wire  [WIDTH-1:0] bus,
   input  logic             load_n,
   input  logic             enable_output,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [CNT_W-1:0] shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] regA,
   output logic             zero,
   output logic             carry
);

   state_t           state_q;
   logic [1:0]       sh_mode_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       step_mode;
   logic [WIDTH-1:0] step_a;
   logic             step_bit;

   // First step uses the live opcode; later steps use the latched one.
   assign step_mode = (state_q == ST_BUSY) ? sh_mode_q : op[1:0];

   acc_shift_step #(.WIDTH(WIDTH)) u_step (
      .a       (regA),
      .mode    (step_mode),
      .next_a  (step_a),
      .bit_out (step_bit)
   );

   assign bus  = enable_output ? regA : {WIDTH{1'bz}};
   assign zero = (regA == '0);
   assign busy = (state_q == ST_BUSY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sh_mode_q <= 2'b00;
         cnt_q     <= '0;
         regA      <= '0;
         carry     <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!load_n) begin
                  regA <= bus;
                  done <= 1'b1;
               end else if (op_valid) begin
                  case (op)
                     OP_NOP: done <= 1'b1;
                     OP_CLR: begin
                        regA  <= '0;
                        carry <= 1'b0;
                        done  <= 1'b1;
                     end
                     OP_INC: begin
                        {carry, regA} <= {1'b0, regA} + (WIDTH+1)'(1);
                        done          <= 1'b1;
                     end
                     OP_DEC: begin
                        regA  <= regA - WIDTH'(1);
                        carry <= (regA == '0);
                        done  <= 1'b1;
                     end
                     default: begin
                        // Shifts: zero count is a no-op, otherwise the first step happens now.
                        if (shamt == '0) begin
                           done <= 1'b1;
                        end else begin
                           regA      <= step_a;
                           carry     <= step_bit;
                           sh_mode_q <= op[1:0];
                           cnt_q     <= shamt - CNT_W'(1);
                           if (shamt == CNT_W'(1)) done <= 1'b1;
                           else                    state_q <= ST_BUSY;
                        end
                     end
                  endcase
               end
            end
            ST_BUSY: begin
               regA  <= step_a;
               carry <= step_bit;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_IDLE;
                  done    <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accumulator_shift_unit.sv
// Self-checking bench: directed vector table, hand sequences and random ops against an arithmetic model.
module tb_accumulator_shift_unit;
   import acc_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   wire  [W-1:0]  bus;
   logic          load_n, enable_output, op_valid;
   logic [2:0]    op;
   logic [CW-1:0] shamt;
   logic          busy, done, zero, carry;
   logic [W-1:0]  regA;
   logic          drv_en;
   logic [W-1:0]  drv_val;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state (accumulator and carry flag).
   logic [W-1:0] m_a;
   logic         m_c;

   assign bus = drv_en ? drv_val : {W{1'bz}};

   always #5 clk = ~clk;

   accumulator_shift_unit #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .load_n(load_n),
      .enable_output(enable_output), .op_valid(op_valid), .op(op),
      .shamt(shamt), .busy(busy), .done(done), .regA(regA),
      .zero(zero), .carry(carry)
   );

   typedef struct {
      logic [W-1:0] init;
      logic [2:0]   op;
      int           n;
      logic [W-1:0] exp_a;
      logic         exp_c;
      int           exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: result of applying op with count n to (a, c), from plain arithmetic.
   function automatic void ref_op(input logic [2:0] o, input int n, input logic [W-1:0] a,
                                  input logic c, output logic [W-1:0] ra, output logic rc);
      int ai, k, r;
      ai = int'(a);
      k  = n % W;
      r  = ai;
      rc = c;
      case (o)
         OP_NOP: r = ai;
         OP_CLR: begin r = 0; rc = 1'b0; end
         OP_INC: begin r = (ai + 1) % 256; rc = (ai == 255); end
         OP_DEC: begin r = (ai + 255) % 256; rc = (ai == 0); end
         OP_SHL: if (n > 0) begin
            r  = (n >= 8) ? 0 : ((ai << n) & 255);
            rc = (n <= 8) ? 1'((ai >> (8 - n)) & 1) : 1'b0;
         end
         OP_SHR: if (n > 0) begin
            r  = (n >= 8) ? 0 : (ai >> n);
            rc = (n <= 8) ? 1'((ai >> (n - 1)) & 1) : 1'b0;
         end
         OP_ROL: if (n > 0) begin
            r  = ((ai << k) | (ai >> (8 - k))) & 255;
            rc = 1'(r & 1);
         end
         default: if (n > 0) begin
            r  = ((ai >> k) | (ai << (8 - k))) & 255;
            rc = 1'((r >> 7) & 1);
         end
      endcase
      ra = W'(r);
   endfunction

   task automatic do_load(input logic [W-1:0] v);
      enable_output = 1'b0;
      drv_en  = 1'b1;
      drv_val = v;
      load_n  = 1'b0;
      tick();
      load_n = 1'b1;
      drv_en = 1'b0;
      m_a = v;
      check("load_regA", 32'(regA), 32'(v));
      check("load_done", 32'(done), 32'd1);
   endtask

   // Issue op, wait for done, verify latency, busy cycles and (if driven) bus trace.
   task automatic run_op(input logic [2:0] o, input int n, input logic eo, input string tag);
      logic [W-1:0] a0, ia, fa;
      logic         c0, ic, fc;
      int           lat, bcnt, exp_lat;
      a0 = m_a;
      c0 = m_c;
      enable_output = eo;
      op_valid = 1'b1;
      op       = o;
      shamt    = CW'(n);
      tick();
      op_valid = 1'b0;
      lat  = 1;
      bcnt = 0;
      forever begin
         if (eo) begin
            ref_op(o, (o[2] && lat < n) ? lat : n, a0, c0, ia, ic);
            check({tag, "_bus"}, 32'(bus), 32'(ia));
         end
         if (busy) bcnt++;
         if (done || lat >= 40) break;
         tick();
         lat++;
      end
      exp_lat = (o[2] && n > 0) ? n : 1;
      ref_op(o, n, a0, c0, fa, fc);
      m_a = fa;
      m_c = fc;
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busycyc"}, 32'(bcnt), 32'(exp_lat - 1));
      check({tag, "_regA"}, 32'(regA), 32'(fa));
      check({tag, "_carry"}, 32'(carry), 32'(fc));
      check({tag, "_zero"}, 32'(zero), 32'(fa == '0));
      enable_output = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; load_n = 1'b1; enable_output = 1'b0; op_valid = 1'b0;
      op = OP_NOP; shamt = '0; drv_en = 1'b0; drv_val = '0;
      m_a = '0; m_c = 1'b0;
      vecs.push_back('{8'hFF, OP_INC, 0, 8'h00, 1'b1, 1});
      vecs.push_back('{8'h00, OP_DEC, 0, 8'hFF, 1'b1, 1});
      vecs.push_back('{8'h81, OP_ROL, 3, 8'h0C, 1'b0, 3});
      vecs.push_back('{8'h81, OP_SHR, 1, 8'h40, 1'b1, 1});
      vecs.push_back('{8'hFF, OP_SHL, 9, 8'h00, 1'b0, 9});
      vecs.push_back('{8'h81, OP_ROR, 1, 8'hC0, 1'b1, 1});
      vecs.push_back('{8'h5A, OP_CLR, 0, 8'h00, 1'b0, 1});
      vecs.push_back('{8'h80, OP_SHL, 1, 8'h00, 1'b1, 1});
      vecs.push_back('{8'h96, OP_ROL, 8, 8'h96, 1'b0, 8});
      vecs.push_back('{8'h80, OP_SHR, 8, 8'h00, 1'b1, 8});
      vecs.push_back('{8'h7F, OP_INC, 0, 8'h80, 1'b0, 1});
      vecs.push_back('{8'h10, OP_DEC, 0, 8'h0F, 1'b0, 1});
      vecs.push_back('{8'h01, OP_ROR, 12, 8'h10, 1'b0, 12});

      #12;
      check("rst_regA", 32'(regA), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_zero", 32'(zero), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle_done", 32'(done), 32'd0);

      // Load from external driver, single done pulse.
      do_load(8'hA5);
      check("load_zero", 32'(zero), 32'd0);
      tick();
      check("load_done_clr", 32'(done), 32'd0);
      check("load_hold", 32'(regA), 32'hA5);

      // Directed table.
      foreach (vecs[i]) begin
         do_load(vecs[i].init);
         run_op(vecs[i].op, vecs[i].n, 1'b1, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_tbl_a", i), 32'(regA), 32'(vecs[i].exp_a));
         check($sformatf("vec%0d_tbl_c", i), 32'(carry), 32'(vecs[i].exp_c));
      end

      // ROL 3 trace with load and op_valid attempted mid-shift (both dropped).
      do_load(8'h81);
      op_valid = 1'b1; op = OP_ROL; shamt = CW'(3);
      tick();
      check("rol_e1_busy", 32'(busy), 32'd1);
      check("rol_e1_done", 32'(done), 32'd0);
      check("rol_e1_a", 32'(regA), 32'h03);
      op = OP_CLR; load_n = 1'b0; drv_en = 1'b1; drv_val = 8'h55;
      tick();
      check("rol_e2_busy", 32'(busy), 32'd1);
      check("rol_e2_a", 32'(regA), 32'h06);
      op_valid = 1'b0; load_n = 1'b1; drv_en = 1'b0;
      tick();
      check("rol_e3_busy", 32'(busy), 32'd0);
      check("rol_e3_done", 32'(done), 32'd1);
      check("rol_e3_a", 32'(regA), 32'h0C);
      check("rol_e3_c", 32'(carry), 32'd0);
      tick();
      check("rol_e4_done", 32'(done), 32'd0);
      m_a = 8'h0C; m_c = 1'b0;

      // Zero shift count keeps carry; set carry first with an INC wrap.
      do_load(8'hFF);
      run_op(OP_INC, 0, 1'b0, "wrap");
      run_op(OP_SHR, 0, 1'b0, "sh0");
      check("sh0_carry_kept", 32'(carry), 32'd1);
      run_op(OP_NOP, 0, 1'b1, "nop");

      // Asynchronous reset in the middle of a long shift.
      do_load(8'hFF);
      op_valid = 1'b1; op = OP_SHL; shamt = CW'(9);
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("mrst_regA", 32'(regA), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_carry", 32'(carry), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("mrst_post_done", 32'(done), 32'd0);
      check("mrst_post_busy", 32'(busy), 32'd0);
      m_a = '0; m_c = 1'b0;

      // Random ops against the model, back-to-back issue.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 2) == 0) do_load(W'($urandom));
         run_op(3'($urandom), int'($urandom_range(0, 12)), 1'($urandom), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
